// File: rtl/prbs_checker_if.sv
// Word-stream bundle between a PRBS word source and the prbs_checker:
// received word, strobes and the checker's lock/error status.
interface prbs_checker_if #(
    parameter int ERR_W = 16
);
    logic             en;
    logic [7:0]       data_in;
    logic             clr_cnt;
    logic             locked;
    logic [1:0]       sync_state;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, data_in, clr_cnt,
        input  locked, sync_state, err_pulse, err_count
    );

    modport slave (
        input  en, data_in, clr_cnt,
        output locked, sync_state, err_pulse, err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Receive-side checker for the 8-bit Galois PRBS (x^8+x^4+x^3+x^2+1): hunts for the
// stream, locks after LOCK_CNT predicted hits, then flywheels and counts mismatches.
module prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_prev, w_prev_nxt, w_pred;
    logic [MW-1:0]    r_match, w_match_nxt, w_match_inc;
    logic [LW-1:0]    r_miss, w_miss_nxt, w_miss_inc;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
    logic             w_hit, w_zero, w_lock_miss;

    // One Galois step: shift up, fold bit 7 back into taps 0,2,3,4.
    assign w_pred      = {r_prev[6:0], 1'b0} ^ (r_prev[7] ? 8'h1D : 8'h00);
    assign w_zero      = (bus.data_in == 8'h00);
    assign w_hit       = (bus.data_in == w_pred);
    assign w_match_inc = r_match + MW'(1);
    assign w_miss_inc  = r_miss + LW'(1);
    assign w_lock_miss = bus.en && (r_state == LOCK) && !w_hit;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_prev      <= 8'h00;
            r_match     <= '0;
            r_miss      <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_match     <= w_match_nxt;
            r_miss      <= w_miss_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        if (bus.en) begin
            case (r_state)
                HUNT: begin
                    if (!w_zero) begin
                        w_prev_nxt  = bus.data_in;
                        w_match_nxt = '0;
                        w_state_nxt = ACQ;
                    end
                end
                ACQ: begin
                    w_prev_nxt = bus.data_in;
                    if (w_hit && !w_zero) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == MW'(LOCK_CNT)) begin
                            w_state_nxt = LOCK;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                        if (w_zero) w_state_nxt = HUNT;
                    end
                end
                LOCK: begin
                    // Flywheel: the predictor ignores the received word once locked.
                    w_prev_nxt = w_pred;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else if (w_miss_inc == LW'(LOSS_CNT)) begin
                        w_state_nxt = HUNT;
                        w_match_nxt = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_err_pulse_nxt = w_lock_miss;
        w_err_count_nxt = r_err_count;
        if (bus.clr_cnt) begin
            // A miss coinciding with a clear survives as a count of one.
            w_err_count_nxt = w_lock_miss ? ERR_W'(1) : '0;
        end else if (w_lock_miss && (r_err_count != '1)) begin
            w_err_count_nxt = r_err_count + ERR_W'(1);
        end
    end

    assign bus.locked     = (r_state == LOCK);
    assign bus.sync_state = r_state;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_prbs_checker.sv
// Directed scoreboard bench for prbs_checker: a default instance (ERR_W=16) for lock,
// error, idle and loss behaviour, and an ERR_W=2 instance for saturation and clear.
module tb_prbs_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    prbs_checker_if #(.ERR_W(16)) bus_a ();
    prbs_checker_if #(.ERR_W(2))  bus_b ();

    prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        bit          sel;
        logic        lk;
        logic [1:0]  st;
        logic        ep;
        logic [15:0] ec;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] gen;

    // Next generator word, written bit-by-bit from the polynomial's tap equations.
    function automatic logic [7:0] nxt(input logic [7:0] x);
        logic [7:0] n;
        n[0] = x[7];
        n[1] = x[0];
        n[2] = x[1] ^ x[7];
        n[3] = x[2] ^ x[7];
        n[4] = x[3] ^ x[7];
        n[5] = x[4];
        n[6] = x[5];
        n[7] = x[6];
        return n;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit sel, input logic r, input logic e, input logic [7:0] d,
                        input logic c, input logic lk, input logic [1:0] st, input logic ep,
                        input logic [15:0] ec, input string tag);
        exp_t x;
        if (!sel) begin
            rst_a = r; bus_a.en = e; bus_a.data_in = d; bus_a.clr_cnt = c;
            rst_b = 1'b0; bus_b.en = 1'b0; bus_b.data_in = 8'h00; bus_b.clr_cnt = 1'b0;
        end else begin
            rst_b = r; bus_b.en = e; bus_b.data_in = d; bus_b.clr_cnt = c;
            rst_a = 1'b0; bus_a.en = 1'b0; bus_a.data_in = 8'h00; bus_a.clr_cnt = 1'b0;
        end
        x = '{sel, lk, st, ep, ec, tag};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (!x.sel) begin
            cmp({x.tag, "/locked"},     16'(bus_a.locked),     16'(x.lk));
            cmp({x.tag, "/sync_state"}, 16'(bus_a.sync_state), 16'(x.st));
            cmp({x.tag, "/err_pulse"},  16'(bus_a.err_pulse),  16'(x.ep));
            cmp({x.tag, "/err_count"},  16'(bus_a.err_count),  x.ec);
        end else begin
            cmp({x.tag, "/locked"},     16'(bus_b.locked),     16'(x.lk));
            cmp({x.tag, "/sync_state"}, 16'(bus_b.sync_state), 16'(x.st));
            cmp({x.tag, "/err_pulse"},  16'(bus_b.err_pulse),  16'(x.ep));
            cmp({x.tag, "/err_count"},  16'(bus_b.err_count),  x.ec);
        end
    endtask

    task automatic tru(input bit sel, input logic lk, input logic [1:0] st, input logic ep,
                       input logic [15:0] ec, input string tag);
        step(sel, 1'b0, 1'b1, gen, 1'b0, lk, st, ep, ec, tag);
        gen = nxt(gen);
    endtask

    task automatic bad(input bit sel, input logic c, input logic lk, input logic [1:0] st,
                       input logic ep, input logic [15:0] ec, input string tag);
        step(sel, 1'b0, 1'b1, gen ^ 8'h5A, c, lk, st, ep, ec, tag);
        gen = nxt(gen);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset and lock-up word in HUNT
        step(0, 1, 0, 8'h00, 0, 0, 2'd0, 0, 0, "reset");
        step(0, 0, 1, 8'h00, 0, 0, 2'd0, 0, 0, "hunt_zero");

        // Acquire FF,E3,DB,... and lock one edge after the 5th word
        gen = 8'hFF;
        for (int i = 0; i < 4; i++) tru(0, 0, 2'd1, 0, 0, "acq");
        tru(0, 1, 2'd2, 0, 0, "lock");
        tru(0, 1, 2'd2, 0, 0, "locked_hit");

        // Single corrupted word, then the true sequence resumes
        bad(0, 0, 1, 2'd2, 1, 1, "single_err");
        for (int i = 0; i < 3; i++) tru(0, 1, 2'd2, 0, 1, "resume");

        // en low with garbage: nothing moves, prediction still aligned afterward
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 8'($urandom), 0, 1, 2'd2, 0, 1, "idle");
        for (int i = 0; i < 2; i++) tru(0, 1, 2'd2, 0, 1, "after_idle");

        // Clear without a miss, then a hit between misses resets the loss run
        step(0, 0, 0, 8'h00, 1, 1, 2'd2, 0, 0, "clr_idle");
        bad(0, 0, 1, 2'd2, 1, 1, "run_m1");
        bad(0, 0, 1, 2'd2, 1, 2, "run_m2");
        tru(0, 1, 2'd2, 0, 2, "run_hit");
        bad(0, 0, 1, 2'd2, 1, 3, "run_m3");
        bad(0, 0, 1, 2'd2, 1, 4, "run_m4");
        tru(0, 1, 2'd2, 0, 4, "run_hit2");

        // Three consecutive misses drop lock; true sequence re-locks after 5 words
        step(0, 0, 0, 8'h00, 1, 1, 2'd2, 0, 0, "clr_before_loss");
        bad(0, 0, 1, 2'd2, 1, 1, "loss_m1");
        bad(0, 0, 1, 2'd2, 1, 2, "loss_m2");
        bad(0, 0, 0, 2'd0, 1, 3, "loss_m3");
        for (int i = 0; i < 4; i++) tru(0, 0, 2'd1, 0, 3, "reacq");
        tru(0, 1, 2'd2, 0, 3, "relock");

        // Reset mid-lock with a bad word present: all outputs clear, no pulse
        step(0, 1, 1, gen ^ 8'h5A, 0, 0, 2'd0, 0, 0, "rst_midlock");

        // Zero word in ACQ returns to HUNT
        gen = 8'hFF;
        tru(0, 0, 2'd1, 0, 0, "acq_enter");
        step(0, 0, 1, 8'h00, 0, 0, 2'd0, 0, 0, "acq_zero");

        // Nonzero miss in ACQ restarts the match run from the new word
        gen = 8'hFF;
        tru(0, 0, 2'd1, 0, 0, "acq2_w1");
        tru(0, 0, 2'd1, 0, 0, "acq2_w2");
        step(0, 0, 1, 8'h55, 0, 0, 2'd1, 0, 0, "acq_miss");
        gen = nxt(8'h55);
        for (int i = 0; i < 3; i++) tru(0, 0, 2'd1, 0, 0, "acq_resync");
        tru(0, 1, 2'd2, 0, 0, "acq_resync_lock");

        // ERR_W=2 instance: saturation, clear with miss, reset while locked
        step(1, 1, 0, 8'h00, 0, 0, 2'd0, 0, 0, "b_reset");
        gen = 8'hFF;
        for (int i = 0; i < 4; i++) tru(1, 0, 2'd1, 0, 0, "b_acq");
        tru(1, 1, 2'd2, 0, 0, "b_lock");
        bad(1, 0, 1, 2'd2, 1, 1, "b_m1");
        bad(1, 0, 1, 2'd2, 1, 2, "b_m2");
        tru(1, 1, 2'd2, 0, 2, "b_hit");
        bad(1, 0, 1, 2'd2, 1, 3, "b_m3");
        bad(1, 0, 1, 2'd2, 1, 3, "b_sat");
        tru(1, 1, 2'd2, 0, 3, "b_hit2");
        bad(1, 1, 1, 2'd2, 1, 1, "b_clr_miss");
        step(1, 1, 0, 8'h00, 0, 0, 2'd0, 0, 0, "b_rst_locked");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
